// File: rtl/frb_burst_scheduler.sv
// frb_burst_scheduler: replays the stored FRB pulse a programmed number of
// times by gating the enable of the BRAM address counter. Bursts are separated
// by a programmable idle gap and can each be held until an external trigger.
// Optional build macro: FRB_TRIG_SYNC_EN puts a two-flop synchroniser on
// ext_trig, which adds 2 cycles of trigger latency.
module frb_burst_scheduler #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 32
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             cfg_trig_mode,
  input  logic [CNT_W-1:0] cfg_bursts,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             ext_trig,
  input  logic             ctr_finish,
  output logic             ctr_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] bursts_done
);

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, RUN, GAP} state_t;

  state_t           state, state_next;
  logic             cfg_start_d;
  logic             start_armed;
  logic             start_edge;
  logic             trig;
  logic [CNT_W-1:0] lat_bursts;
  logic [GAP_W-1:0] lat_gap;
  logic             lat_trig;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] count_inc;
  logic             do_start, do_finish, do_done, do_abort, do_load_gap, do_dec_gap;

  // Burst counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef FRB_TRIG_SYNC_EN
  logic trig_s1, trig_s2;

  // Two-flop synchroniser for an ext_trig that may be asynchronous to the clock.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
    end else begin
      trig_s1 <= ext_trig;
      trig_s2 <= trig_s1;
    end
  end

  assign trig = trig_s2;
`else
  assign trig = ext_trig;
`endif

  // start_armed blocks the first cycle after reset, so a cfg_start that is
  // already high at release is absorbed into cfg_start_d rather than seen as
  // an edge.
  assign start_edge = cfg_start & ~cfg_start_d & start_armed;
  assign count_inc  = sat_inc(bursts_done);
  assign ctr_en     = (state == RUN);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_next;
  end

  // Next-state decode and per-cycle action strobes; abort overrides everything.
  always_comb begin
    state_next  = state;
    do_start    = 1'b0;
    do_finish   = 1'b0;
    do_done     = 1'b0;
    do_abort    = 1'b0;
    do_load_gap = 1'b0;
    do_dec_gap  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge && !cfg_abort) begin
          do_start   = 1'b1;
          state_next = cfg_trig_mode ? WAIT_TRIG : RUN;
        end
      end
      WAIT_TRIG: begin
        if (trig) state_next = RUN;
      end
      RUN: begin
        if (ctr_finish) begin
          do_finish = 1'b1;
          if ((lat_bursts != '0) && (count_inc == lat_bursts)) begin
            do_done    = 1'b1;
            state_next = IDLE;
          end else begin
            do_load_gap = 1'b1;
            state_next  = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_next = lat_trig ? WAIT_TRIG : RUN;
        else               do_dec_gap = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (cfg_abort && (state != IDLE)) begin
      state_next  = IDLE;
      do_finish   = 1'b0;
      do_done     = 1'b0;
      do_load_gap = 1'b0;
      do_dec_gap  = 1'b0;
      do_abort    = 1'b1;
    end
  end

  // Control registers: start edge detect, gap counter, status and sticky flags.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      cfg_start_d <= 1'b0;
      start_armed <= 1'b0;
      gap_cnt     <= '0;
      bursts_done <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      cfg_start_d <= cfg_start;
      start_armed <= 1'b1;
      if (do_load_gap)     gap_cnt <= lat_gap;
      else if (do_dec_gap) gap_cnt <= gap_cnt - {{(GAP_W-1){1'b0}}, 1'b1};
      if (do_start) begin
        bursts_done <= '0;
        done        <= 1'b0;
        aborted     <= 1'b0;
      end
      if (do_finish) bursts_done <= count_inc;
      if (do_done)   done        <= 1'b1;
      if (do_abort)  aborted     <= 1'b1;
    end
  end

  // Configuration snapshot taken only when a sequence launches.
  always_ff @(posedge S_AXI_ACLK) begin
    if (do_start) begin
      lat_bursts <= cfg_bursts;
      lat_gap    <= cfg_gap;
      lat_trig   <= cfg_trig_mode;
    end
  end

endmodule

// File: tb/tb_frb_burst_scheduler.sv
// Testbench for frb_burst_scheduler. Stimulus pushes expected burst-window,
// gap and latency records plus status snapshots into queues; a monitor on the
// falling clock edge pops and compares them as the DUT produces them.
module tb_frb_burst_scheduler;
  localparam int CNT_W = 16;
  localparam int GAP_W = 32;
`ifdef FRB_TRIG_SYNC_EN
  localparam int TRIG_LAT = 3;
`else
  localparam int TRIG_LAT = 1;
`endif

  localparam int K_SLAT = 0;
  localparam int K_LAT  = 1;
  localparam int K_GAP  = 2;
  localparam int K_WIN  = 3;
  localparam int K_STAT = 4;

  localparam int S_EN   = 0;
  localparam int S_BUSY = 1;
  localparam int S_DONE = 2;
  localparam int S_AB   = 3;
  localparam int S_BD   = 4;

  typedef struct {
    int    kind;
    int    a;
    int    b;
    int    c;
    string name;
  } item_t;

  logic             clk;
  logic             rst_n;
  logic             cfg_start, cfg_abort, cfg_trig_mode;
  logic [CNT_W-1:0] cfg_bursts;
  logic [GAP_W-1:0] cfg_gap;
  logic             ext_trig, ctr_finish;
  logic             ctr_en, busy, done, aborted;
  logic [CNT_W-1:0] bursts_done;

  item_t sb_q[$];
  item_t stat_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    burst_len = 10;
  bit    end_req = 0;

  frb_burst_scheduler #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_trig_mode(cfg_trig_mode),
    .cfg_bursts   (cfg_bursts),
    .cfg_gap      (cfg_gap),
    .ext_trig     (ext_trig),
    .ctr_finish   (ctr_finish),
    .ctr_en       (ctr_en),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .bursts_done  (bursts_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int get_sig(input int s);
    case (s)
      S_EN:    return int'(ctr_en);
      S_BUSY:  return int'(busy);
      S_DONE:  return int'(done);
      S_AB:    return int'(aborted);
      S_BD:    return int'(bursts_done);
      default: return -1;
    endcase
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_item(input int k, input int a, input int b, input int c);
    item_t it;
    it.kind = k; it.a = a; it.b = b; it.c = c; it.name = "";
    sb_q.push_back(it);
  endtask

  task automatic push_stat(input string name, input int s, input int v);
    item_t it;
    it.kind = K_STAT; it.a = s; it.b = v; it.c = 0; it.name = name;
    stat_q.push_back(it);
  endtask

  task automatic wait_until(input int s, input int val, input int limit, input string what);
    int n;
    n = 0;
    while (get_sig(s) != val) begin
      tick();
      n++;
      if (n > limit) begin
        $display("FAIL timeout_%s: waited %0d cycles, signal %0d never reached %0d", what, limit, s, val);
        $fatal(1, "bounded wait expired");
      end
    end
  endtask

  // Address-counter stand-in: pulses ctr_finish after burst_len enabled cycles.
  initial begin
    int en_cnt;
    en_cnt = 0;
    ctr_finish = 1'b0;
    forever begin
      tick();
      if (ctr_en) begin
        en_cnt++;
        if (en_cnt >= burst_len) begin
          ctr_finish = 1'b1;
          en_cnt = 0;
        end else begin
          ctr_finish = 1'b0;
        end
      end else begin
        en_cnt = 0;
        ctr_finish = 1'b0;
      end
    end
  end

  // Monitor: measures enable windows, gaps and latencies; consumes expectations.
  initial begin
    int    cyc, start_cyc, trig_cyc, win_len, gap_len;
    bit    en_prev, start_prev;
    item_t it;
    cyc = 0; start_cyc = 0; trig_cyc = 0; win_len = 0; gap_len = 0;
    en_prev = 0; start_prev = 0;
    forever begin
      @(negedge clk);
      if (end_req) begin
        cmp("queue_drained", sb_q.size() + stat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
      if (!rst_n) begin
        en_prev = 0; win_len = 0; gap_len = 0; start_prev = cfg_start;
      end else begin
        cyc++;
        if (cfg_start && !start_prev) start_cyc = cyc;
        start_prev = cfg_start;
        if (ext_trig) trig_cyc = cyc;
        if (ctr_en && !en_prev) begin
          if (sb_q.size() == 0) cmp("unexpected_en_rise", 1, 0);
          else begin
            it = sb_q.pop_front();
            case (it.kind)
              K_SLAT:  cmp("start_to_en_latency", cyc - start_cyc, it.a);
              K_LAT:   cmp("trig_to_en_latency", cyc - trig_cyc, it.a);
              K_GAP:   cmp("gap_len", gap_len, it.a);
              default: cmp("rise_item_kind", it.kind, K_GAP);
            endcase
          end
          win_len = 0;
          gap_len = 0;
        end
        if (!ctr_en && en_prev && !aborted) begin
          if (sb_q.size() == 0) cmp("unexpected_en_fall", 1, 0);
          else begin
            it = sb_q.pop_front();
            if (it.kind != K_WIN) cmp("fall_item_kind", it.kind, K_WIN);
            else begin
              cmp("win_len", win_len, it.a);
              cmp("bursts_done_at_fall", int'(bursts_done), it.b);
              cmp("done_at_fall", int'(done), it.c);
            end
          end
          gap_len = 0;
        end
        if (ctr_en) win_len++;
        if (!ctr_en && busy) gap_len++;
        if (!busy) gap_len = 0;
        en_prev = ctr_en;
      end
      while (stat_q.size() > 0) begin
        it = stat_q.pop_front();
        cmp(it.name, get_sig(it.a), it.b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_seq(input int n, input int g, input int l, input int trig);
    cfg_bursts    = CNT_W'(n);
    cfg_gap       = GAP_W'(g);
    cfg_trig_mode = (trig != 0);
    burst_len     = l;
    for (int i = 1; i <= n; i++) begin
      if (trig != 0)  push_item(K_LAT, TRIG_LAT, 0, 0);
      else if (i == 1) push_item(K_SLAT, 1, 0, 0);
      else            push_item(K_GAP, g + 1, 0, 0);
      push_item(K_WIN, l, i, (i == n) ? 1 : 0);
    end
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    push_stat("seq_busy", S_BUSY, 1);
    push_stat("seq_aborted_cleared", S_AB, 0);
    push_stat("seq_done_cleared", S_DONE, 0);
    push_stat("seq_bursts_done_cleared", S_BD, 0);
    push_stat("seq_en_after_start", S_EN, (trig != 0) ? 0 : 1);
    if (trig != 0) begin
      for (int i = 1; i <= n; i++) begin
        if (i == 1) begin
          repeat ($urandom_range(2, 6)) tick();
        end else begin
          wait_until(S_EN, 0, l + 5, "win_end");
          repeat (g + 3 + $urandom_range(0, 4)) tick();
        end
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        wait_until(S_EN, 1, 10, "trig_en");
      end
    end
    wait_until(S_BUSY, 0, n * (l + g + 20) + 50, "seq_end");
    push_stat("seq_done_set", S_DONE, 1);
    push_stat("seq_bursts_done_final", S_BD, n);
    push_stat("seq_en_idle", S_EN, 0);
    tick();
    tick();
  endtask

  // Stimulus.
  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_trig_mode = 1'b0;
    cfg_bursts = '0; cfg_gap = '0; ext_trig = 1'b0;
    #1;
    push_stat("reset_ctr_en", S_EN, 0);
    push_stat("reset_busy", S_BUSY, 0);
    push_stat("reset_done", S_DONE, 0);
    push_stat("reset_aborted", S_AB, 0);
    push_stat("reset_bursts_done", S_BD, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // finite, zero-gap and triggered sequences
    run_seq(3, 5, 10, 0);
    run_seq(2, 0, 7, 0);
    run_seq(2, 3, 9, 1);

    // abort mid-RUN with a simultaneous start edge, then restart
    cfg_bursts = 4; cfg_gap = 2; cfg_trig_mode = 1'b0; burst_len = 8;
    push_item(K_SLAT, 1, 0, 0);
    push_item(K_WIN, 8, 1, 0);
    push_item(K_GAP, 3, 0, 0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_until(S_BD, 1, 30, "abort_first_burst");
    wait_until(S_EN, 1, 10, "abort_second_burst");
    repeat (3) tick();
    cfg_abort = 1'b1;
    cfg_start = 1'b1;
    tick();
    push_stat("abort_ctr_en", S_EN, 0);
    push_stat("abort_busy", S_BUSY, 0);
    push_stat("abort_aborted", S_AB, 1);
    push_stat("abort_done", S_DONE, 0);
    push_stat("abort_bursts_done", S_BD, 1);
    repeat (3) tick();
    push_stat("abort_no_restart", S_BUSY, 0);
    cfg_abort = 1'b0;
    tick();
    push_stat("abort_release_no_restart", S_BUSY, 0);
    cfg_start = 1'b0;
    tick();
    run_seq(2, 1, 5, 0);

    // continuous mode with a start edge and config change while busy
    cfg_bursts = 0; cfg_gap = 20; cfg_trig_mode = 1'b0; burst_len = 6;
    push_item(K_SLAT, 1, 0, 0);
    push_item(K_WIN, 6, 1, 0);
    for (int i = 2; i <= 5; i++) begin
      push_item(K_GAP, 21, 0, 0);
      push_item(K_WIN, 6, i, 0);
    end
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_until(S_BD, 1, 20, "cont_first_burst");
    cfg_start = 1'b1; cfg_bursts = 2; cfg_gap = 0;
    tick();
    cfg_start = 1'b0;
    wait_until(S_BD, 5, 300, "cont_five_bursts");
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    push_stat("cont_busy", S_BUSY, 0);
    push_stat("cont_aborted", S_AB, 1);
    push_stat("cont_no_done", S_DONE, 0);
    push_stat("cont_bursts_done", S_BD, 5);
    tick();

    // asynchronous reset mid-RUN, cfg_start held high through release
    cfg_bursts = 3; cfg_gap = 4; burst_len = 12;
    push_item(K_SLAT, 1, 0, 0);
    push_item(K_WIN, 12, 1, 0);
    push_item(K_GAP, 5, 0, 0);
    cfg_start = 1'b1;
    tick();
    wait_until(S_BD, 1, 30, "rst_first_burst");
    wait_until(S_EN, 1, 20, "rst_second_burst");
    repeat (4) tick();
    #1 rst_n = 1'b0;
    #1;
    push_stat("arst_ctr_en", S_EN, 0);
    push_stat("arst_busy", S_BUSY, 0);
    push_stat("arst_bursts_done", S_BD, 0);
    push_stat("arst_done", S_DONE, 0);
    push_stat("arst_aborted", S_AB, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) begin
      tick();
      push_stat("held_start_stays_idle", S_BUSY, 0);
    end
    cfg_start = 1'b0;
    tick();
    tick();

    // randomized sequences
    repeat (6) begin
      run_seq(int'($urandom_range(1, 4)), int'($urandom_range(0, 7)),
              int'($urandom_range(2, 12)), int'($urandom_range(0, 1)));
    end

    tick();
    end_req = 1'b1;
  end

endmodule
